// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer round sequencer.
`timescale 1ns/1ps
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    SETTLE = 3'd2,
    WAIT   = 3'd3,
    LIT    = 3'd4,
    DONE   = 3'd5,
    CHEAT  = 3'd6
  } state_e;

  localparam logic [11:0] CNT_MAX       = 12'd4095;
  localparam logic [11:0] DELAY_MIN_DEF = 12'd1000;
  localparam logic [11:0] LFSR_SEED_DEF = 12'hACE;
  // Fibonacci taps 12,6,4,1 expressed as bit positions 11,5,3,0
  localparam logic [11:0] LFSR_TAPS     = 12'h829;

  function automatic logic in_round(input state_e s);
    return (s == ARM) || (s == SETTLE) || (s == WAIT) || (s == LIT);
  endfunction

endpackage

// File: rtl/lfsr12.sv
// Free-running 12-bit Fibonacci LFSR; advances every clock, seeded on async reset.
`timescale 1ns/1ps
module lfsr12
  import reaction_pkg::*;
#(
  parameter logic [11:0] SEED = LFSR_SEED_DEF,
  parameter logic [11:0] TAPS = LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] q
);

  logic [11:0] q_q;
  logic [11:0] q_d;

  always_comb begin
    q_d = {q_q[10:0], ^(q_q & TAPS)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer round sequencer: random delay, stimulus LED, response timing.
// Optional best-time tracking is enabled by defining REACTION_BEST_EN.
`timescale 1ns/1ps
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter logic [11:0] DELAY_MIN = DELAY_MIN_DEF,
  parameter logic [11:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic        clk1k,
  input  logic        reset,
  input  logic        go,
  input  logic        react,
  input  logic        dc_done,
  output logic        dc_start,
  output logic [11:0] dc_value,
  output logic        led,
  output logic [11:0] result,
  output logic        result_valid,
  output logic        timeout,
  output logic        cheat,
`ifdef REACTION_BEST_EN
  output logic [11:0] best,
`endif
  output logic        busy
);

  state_e      state_q, state_d;
  logic        dc_start_q, dc_start_d;
  logic [11:0] dc_value_q, dc_value_d;
  logic        led_q, led_d;
  logic [11:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        timeout_q, timeout_d;
  logic        cheat_q, cheat_d;
  logic        busy_q, busy_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] lfsr_q;
  logic        go_ok;
`ifdef REACTION_BEST_EN
  logic [11:0] best_q, best_d;
`endif

  lfsr12 #(
    .SEED(LFSR_SEED),
    .TAPS(LFSR_TAPS)
  ) u_lfsr (
    .clk(clk1k),
    .rst(reset),
    .q  (lfsr_q)
  );

  assign go_ok = go && !react;

  always_comb begin
    state_d        = state_q;
    dc_start_d     = 1'b0;
    dc_value_d     = dc_value_q;
    led_d          = led_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    timeout_d      = timeout_q;
    cheat_d        = cheat_q;
    cnt_d          = cnt_q;
`ifdef REACTION_BEST_EN
    best_d         = best_q;
`endif

    case (state_q)
      IDLE, DONE, CHEAT: begin
        // Outputs are registered, so the load pulse and delay are set on the edge entering ARM.
        if (go_ok) begin
          state_d        = ARM;
          dc_start_d     = 1'b1;
          dc_value_d     = DELAY_MIN + (lfsr_q & 12'h7FF);
          result_d       = '0;
          result_valid_d = 1'b0;
          timeout_d      = 1'b0;
          cheat_d        = 1'b0;
        end
      end
      ARM: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (react) begin
          state_d = CHEAT;
          cheat_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (react) begin
          state_d = CHEAT;
          cheat_d = 1'b1;
        end else if (dc_done) begin
          state_d = LIT;
          led_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      LIT: begin
        if (react) begin
          state_d        = DONE;
          result_d       = cnt_q;
          result_valid_d = 1'b1;
          led_d          = 1'b0;
`ifdef REACTION_BEST_EN
          if (cnt_q < best_q) begin
            best_d = cnt_q;
          end
`endif
        end else if (cnt_q == CNT_MAX) begin
          state_d        = DONE;
          result_d       = CNT_MAX;
          result_valid_d = 1'b1;
          timeout_d      = 1'b1;
          led_d          = 1'b0;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = in_round(state_d);
  end

  always_ff @(posedge clk1k or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      dc_start_q     <= 1'b0;
      dc_value_q     <= '0;
      led_q          <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      cheat_q        <= 1'b0;
      busy_q         <= 1'b0;
      cnt_q          <= '0;
`ifdef REACTION_BEST_EN
      best_q         <= CNT_MAX;
`endif
    end else begin
      state_q        <= state_d;
      dc_start_q     <= dc_start_d;
      dc_value_q     <= dc_value_d;
      led_q          <= led_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      cheat_q        <= cheat_d;
      busy_q         <= busy_d;
      cnt_q          <= cnt_d;
`ifdef REACTION_BEST_EN
      best_q         <= best_d;
`endif
    end
  end

  assign dc_start     = dc_start_q;
  assign dc_value     = dc_value_q;
  assign led          = led_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign cheat        = cheat_q;
  assign busy         = busy_q;
`ifdef REACTION_BEST_EN
  assign best         = best_q;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Self-checking bench for reaction_ctrl with a behavioural down-counter and round model.
`timescale 1ns/1ps
module tb_reaction_ctrl;

  logic        clk1k = 1'b0;
  logic        reset;
  logic        go;
  logic        react;
  logic        dc_done;
  logic        dc_start;
  logic [11:0] dc_value;
  logic        led;
  logic [11:0] result;
  logic        result_valid;
  logic        timeout;
  logic        cheat;
  logic        busy;
`ifdef REACTION_BEST_EN
  logic [11:0] best;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  reaction_ctrl #(
    .DELAY_MIN(12'd1000),
    .LFSR_SEED(12'hACE)
  ) dut (
    .clk1k       (clk1k),
    .reset       (reset),
    .go          (go),
    .react       (react),
    .dc_done     (dc_done),
    .dc_start    (dc_start),
    .dc_value    (dc_value),
    .led         (led),
    .result      (result),
    .result_valid(result_valid),
    .timeout     (timeout),
    .cheat       (cheat),
`ifdef REACTION_BEST_EN
    .best        (best),
`endif
    .busy        (busy)
  );

  always #5 clk1k = ~clk1k;

  // External millisecond down-counter; ovr forces a stale done flag.
  logic [11:0] dcnt = '0;
  logic        ovr  = 1'b0;
  always @(posedge clk1k) begin
    if (dc_start) dcnt <= dc_value;
    else if (dcnt != 0) dcnt <= dcnt - 12'd1;
  end
  assign dc_done = ovr | (dcnt == 12'd0);

  function automatic logic [11:0] lfsr_next(input logic [11:0] v);
    return {v[10:0], v[11] ^ v[5] ^ v[3] ^ v[0]};
  endfunction

  // m_prev holds the LFSR value that was current during the previous cycle.
  logic [11:0] m_lfsr, m_prev;
  always @(posedge clk1k or posedge reset) begin
    if (reset) begin
      m_lfsr <= 12'hACE;
      m_prev <= 12'hACE;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= lfsr_next(m_lfsr);
    end
  end

  int          m_best = 4095;
  int          exp_n;
  int          since_arm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1k);
    @(negedge clk1k);
  endtask

  task automatic start_round(input bit stale);
    go = 1'b1;
    if (stale) ovr = 1'b1;
    step();
    go = 1'b0;
    exp_n = 1000 + int'(m_prev[10:0]);
    chk("arm_dc_start", dc_start, 1);
    chk("arm_busy", busy, 1);
    chk("arm_dc_value", dc_value, exp_n);
    chk("arm_cleared", {result, result_valid, timeout, cheat, led}, 0);
    step();
    since_arm = 1;
    chk("settle_dc_start", dc_start, 0);
    chk("settle_led", led, 0);
    if (stale) begin
      step();
      since_arm = 2;
      ovr = 1'b0;
      chk("stale_no_led", led, 0);
      chk("stale_busy", busy, 1);
    end
  endtask

  task automatic wait_led();
    while (led !== 1'b1 && since_arm < 4000) begin
      step();
      since_arm++;
    end
    chk("led_rise_cycle", since_arm, exp_n + 2);
  endtask

  task automatic lit_phase(input int r);
    int done_i;
    int exp_res;
    bit exp_to;
    done_i  = -1;
    exp_res = (r > 4095) ? 4095 : r;
    exp_to  = (r > 4095);
    for (int i = 0; i < 4300; i++) begin
      if (i == r) react = 1'b1;
      step();
      if (led == 1'b0) begin
        done_i = i;
        break;
      end
    end
    react = 1'b0;
    chk("lit_length", done_i, exp_res);
    chk("result", result, exp_res);
    chk("result_valid", result_valid, 1);
    chk("timeout", timeout, exp_to);
    chk("done_cheat_busy", {cheat, busy}, 0);
    if (!exp_to && exp_res < m_best) m_best = exp_res;
  endtask

  task automatic normal_round(input bit stale, input int r);
    start_round(stale);
    wait_led();
    lit_phase(r);
  endtask

  task automatic cheat_settle();
    start_round(1'b0);
    react = 1'b1;
    step();
    chk("cheat_settle_flag", cheat, 1);
    chk("cheat_settle_rest", {led, result_valid, busy, timeout}, 0);
    react = 1'b0;
    step();
  endtask

  initial begin
    go    = 1'b0;
    react = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk("rst_outputs", {dc_start, led, result_valid, timeout, cheat, busy}, 0);
    chk("rst_result", result, 0);
    chk("rst_dc_value", dc_value, 0);
    chk("rst_lfsr", dut.u_lfsr.q, 12'hACE);
`ifdef REACTION_BEST_EN
    chk("rst_best", best, 4095);
`endif
    reset = 1'b0;
    step();

    // go with react held is ignored in IDLE
    react = 1'b1;
    go    = 1'b1;
    step();
    go    = 1'b0;
    chk("idle_go_react_ignored", {dc_start, busy}, 0);
    react = 1'b0;
    step();

    normal_round(1'b0, 250);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 20)) step();
      normal_round(1'b0, int'($urandom_range(0, 600)));
    end

    // Press during WAIT
    start_round(1'b0);
    repeat ($urandom_range(1, 400)) step();
    chk("wait_no_led_yet", led, 0);
    react = 1'b1;
    step();
    chk("cheat_wait_flag", cheat, 1);
    chk("cheat_wait_rest", {led, result_valid, busy, timeout}, 0);
    chk("cheat_wait_result", result, 0);
    go = 1'b1;
    step();
    go = 1'b0;
    chk("cheat_go_react_ignored", {dc_start, busy}, 0);
    chk("cheat_holds", cheat, 1);
    react = 1'b0;
    step();

    cheat_settle();
    normal_round(1'b1, int'($urandom_range(0, 300)));
    normal_round(1'b0, 5000);
    normal_round(1'b0, 4095);

    // Best-time sequence
    m_best = 4095;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    normal_round(1'b0, 300);
    normal_round(1'b0, 180);
    cheat_settle();
    normal_round(1'b0, 220);
    chk("model_best", m_best, 180);
`ifdef REACTION_BEST_EN
    chk("best", best, m_best);
`endif

    // Asynchronous reset in the middle of LIT
    start_round(1'b0);
    wait_led();
    repeat (10) step();
    #2 reset = 1'b1;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_outputs", {dc_start, result_valid, timeout, cheat, busy}, 0);
    chk("async_rst_values", {dc_value, result}, 0);
    chk("async_rst_lfsr", dut.u_lfsr.q, 12'hACE);
`ifdef REACTION_BEST_EN
    chk("async_rst_best", best, 4095);
`endif
    @(negedge clk1k);
    reset = 1'b0;
    repeat ($urandom_range(0, 5)) step();
    normal_round(1'b0, int'($urandom_range(0, 100)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
